// File: rtl/hsv_core_commit_sink.sv
// hsv_core_commit_sink: retires commit beats, does writeback, counts instret and runs the unit flush handshake.
// commit_data layout: {writeback, rd_addr[4:0], rd_value[31:0], jump, jump_target[31:0]}.
module hsv_core_commit_sink #(
  parameter int NUM_UNITS     = 4,
  parameter int FLUSH_TIMEOUT = 64
) (
  input  logic                 clk_core,
  input  logic                 rst_core_n,
  input  logic [70:0]          commit_data,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 ext_flush_i,
  output logic                 flush_req,
  input  logic [NUM_UNITS-1:0] flush_ack,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_target,
  output logic [63:0]          instret,
  output logic                 flush_timeout
);
  localparam int CW = $clog2(FLUSH_TIMEOUT + 1);
  typedef enum logic {IDLE, FLUSH} state_e;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic          rf_we_q, redirect_valid_q;
  logic [4:0]    rf_waddr_q;
  logic [31:0]   rf_wdata_q, redirect_target_q;
  logic [63:0]   instret_q;
  logic          wb, jmp, accept, do_wb, do_jmp;
  logic [4:0]    rd;
  logic [31:0]   rd_val, tgt;
  assign {wb, rd, rd_val, jmp, tgt} = commit_data;
  assign accept = (state_q == IDLE) && valid_i;
  assign do_wb  = accept && wb && (rd != 5'd0);
  assign do_jmp = accept && jmp;
  // cnt must reach 1 before acks count, so acks still high from before the request are ignored
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    timeout_d = timeout_q;
    if (state_q == IDLE) begin
      state_d = (do_jmp || ext_flush_i) ? FLUSH : IDLE;
    end else begin
      cnt_d     = (cnt_q == CW'(FLUSH_TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
      state_d   = (cnt_q != '0 && &flush_ack) ? IDLE : FLUSH;
      timeout_d = timeout_q || (state_d == FLUSH && cnt_d == CW'(FLUSH_TIMEOUT));
    end
  end
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q           <= FLUSH;
      cnt_q             <= '0;
      timeout_q         <= 1'b0;
      rf_we_q           <= 1'b0;
      rf_waddr_q        <= '0;
      rf_wdata_q        <= '0;
      redirect_valid_q  <= 1'b0;
      redirect_target_q <= '0;
      instret_q         <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      timeout_q        <= timeout_d;
      rf_we_q          <= do_wb;
      redirect_valid_q <= do_jmp;
      if (do_wb) begin
        rf_waddr_q <= rd;
        rf_wdata_q <= rd_val;
      end
      if (do_jmp) redirect_target_q <= tgt;
      if (accept) instret_q <= instret_q + 64'd1;
    end
  end
  assign ready_o         = state_q == IDLE;
  assign flush_req       = state_q == FLUSH;
  assign rf_we           = rf_we_q;
  assign rf_waddr        = rf_waddr_q;
  assign rf_wdata        = rf_wdata_q;
  assign redirect_valid  = redirect_valid_q;
  assign redirect_target = redirect_target_q;
  assign instret         = instret_q;
  assign flush_timeout   = timeout_q;
endmodule

// File: tb/tb_hsv_core_commit_sink.sv
// tb_hsv_core_commit_sink: directed table/sequences plus random traffic against a cycle-stamped reference model.
module tb_hsv_core_commit_sink;
  localparam int N  = 4;
  localparam int TO = 64;
  logic          clk_core = 1'b0, rst_core_n = 1'b1;
  logic [70:0]   commit_data = '0;
  logic          valid_i = 1'b0, ext_flush_i = 1'b0;
  logic          ready_o, flush_req, rf_we, redirect_valid, flush_timeout;
  logic [N-1:0]  flush_ack, ack_q, hold_mask = '0;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata, redirect_target;
  logic [63:0]   instret;
  int            checks = 0, failures = 0;

  hsv_core_commit_sink #(.NUM_UNITS(N), .FLUSH_TIMEOUT(TO)) dut (
    .clk_core(clk_core), .rst_core_n(rst_core_n), .commit_data(commit_data), .valid_i(valid_i),
    .ready_o(ready_o), .ext_flush_i(ext_flush_i), .flush_req(flush_req), .flush_ack(flush_ack),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .instret(instret), .flush_timeout(flush_timeout)
  );

  always #5 clk_core = ~clk_core;

  // execution units: ack is flush_req delayed one cycle, reset to 1; hold_mask stalls chosen units
  always @(posedge clk_core or negedge rst_core_n)
    if (!rst_core_n) ack_q <= '1;
    else ack_q <= {N{flush_req}};
  assign flush_ack = ack_q & ~hold_mask;

  // reference model: flush tracked by the cycle stamp of its first cycle, retirements by a plain count
  logic          c_wb, c_jmp;
  logic [4:0]    c_rd;
  logic [31:0]   c_val, c_tgt;
  assign {c_wb, c_rd, c_val, c_jmp, c_tgt} = commit_data;
  longint        cyc, m_start;
  bit            m_fl, m_we, m_rv, m_to;
  logic [4:0]    m_wa;
  logic [31:0]   m_wd, m_rt;
  logic [63:0]   m_ret, m_base = '0;
  always @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      cyc <= 0; m_start <= 0; m_fl <= 1'b1; m_we <= 1'b0; m_wa <= '0; m_wd <= '0;
      m_rv <= 1'b0; m_rt <= '0; m_ret <= '0; m_to <= 1'b0;
    end else begin
      cyc  <= cyc + 1;
      m_we <= !m_fl && valid_i && c_wb && c_rd != 5'd0;
      m_rv <= !m_fl && valid_i && c_jmp;
      if (!m_fl && valid_i && c_wb && c_rd != 5'd0) begin
        m_wa <= c_rd;
        m_wd <= c_val;
      end
      if (!m_fl && valid_i && c_jmp) m_rt <= c_tgt;
      if (!m_fl) begin
        if (valid_i) m_ret <= m_ret + 64'd1;
        if ((valid_i && c_jmp) || ext_flush_i) begin
          m_fl    <= 1'b1;
          m_start <= cyc + 1;
        end
      end else if (cyc > m_start && &flush_ack) m_fl <= 1'b0;
      else if (cyc + 1 - m_start >= TO) m_to <= 1'b1;
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_core) begin
    #1;
    cmp("m_ready", 64'(ready_o), 64'(!m_fl));
    cmp("m_flush_req", 64'(flush_req), 64'(m_fl));
    cmp("m_rf_we", 64'(rf_we), 64'(m_we));
    if (m_we) begin
      cmp("m_waddr", 64'(rf_waddr), 64'(m_wa));
      cmp("m_wdata", 64'(rf_wdata), 64'(m_wd));
    end
    cmp("m_redirect", 64'(redirect_valid), 64'(m_rv));
    if (m_rv) cmp("m_target", 64'(redirect_target), 64'(m_rt));
    cmp("m_instret", instret, m_base + m_ret);
    cmp("m_timeout", 64'(flush_timeout), 64'(m_to));
  end

  task automatic drive(input logic v, input logic wb, input logic [4:0] rd, input logic [31:0] val,
                       input logic j, input logic [31:0] tgt, input logic ext);
    valid_i     = v;
    commit_data = {wb, rd, val, j, tgt};
    ext_flush_i = ext;
  endtask

  typedef struct {logic wb; logic [4:0] rd; logic [31:0] val; logic exp_we;} beat_t;
  beat_t tbl[3];

  initial begin
    int eps, rvs;
    logic prev_fr;
    bit done;
    tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b1};
    tbl[1] = '{1'b1, 5'd0, 32'h1, 1'b0};
    tbl[2] = '{1'b1, 5'd7, 32'h2, 1'b1};
    #1 rst_core_n = 1'b0;
    repeat (3) @(negedge clk_core);
    cmp("rst_flush_req", 64'(flush_req), 64'd1);
    cmp("rst_ready", 64'(ready_o), 64'd0);
    cmp("rst_instret", instret, 64'd0);
    cmp("rst_rf_we", 64'(rf_we), 64'd0);
    rst_core_n = 1'b1;
    @(negedge clk_core);
    cmp("rel_flush_req_c1", 64'(flush_req), 64'd1);
    @(negedge clk_core);
    cmp("rel_ready", 64'(ready_o), 64'd1);
    cmp("rel_flush_req_low", 64'(flush_req), 64'd0);
    cmp("rel_instret", instret, 64'd0);
    // back-to-back writeback beats, one to x0
    drive(1'b1, tbl[0].wb, tbl[0].rd, tbl[0].val, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_core);
      cmp("tbl_rf_we", 64'(rf_we), 64'(tbl[i].exp_we));
      if (tbl[i].exp_we) begin
        cmp("tbl_waddr", 64'(rf_waddr), 64'(tbl[i].rd));
        cmp("tbl_wdata", 64'(rf_wdata), 64'(tbl[i].val));
      end
      if (i < 2) drive(1'b1, tbl[i+1].wb, tbl[i+1].rd, tbl[i+1].val, 1'b0, '0, 1'b0);
      else drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    end
    cmp("tbl_instret", instret, 64'd3);
    // jump beat
    drive(1'b1, 1'b0, '0, '0, 1'b1, 32'h80000040, 1'b0);
    @(negedge clk_core);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    cmp("jmp_redirect", 64'(redirect_valid), 64'd1);
    cmp("jmp_target", 64'(redirect_target), 64'h80000040);
    cmp("jmp_flush_req", 64'(flush_req), 64'd1);
    cmp("jmp_ready", 64'(ready_o), 64'd0);
    cmp("jmp_instret", instret, 64'd4);
    @(negedge clk_core);
    cmp("jmp_redirect_1cyc", 64'(redirect_valid), 64'd0);
    cmp("jmp_ready_c2", 64'(ready_o), 64'd0);
    @(negedge clk_core);
    cmp("jmp_ready_back", 64'(ready_o), 64'd1);
    // unit 2 stalls its ack for 100 cycles of flush
    hold_mask = 4'b0100;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    @(negedge clk_core);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 100; k++) begin
      if (k == 63) cmp("to_before", 64'(flush_timeout), 64'd0);
      if (k == 64) cmp("to_at_64", 64'(flush_timeout), 64'd1);
      if (k < 99) @(negedge clk_core);
    end
    cmp("to_still_flushing", 64'(flush_req), 64'd1);
    hold_mask = '0;
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk_core);
      done = ready_o;
    end
    cmp("to_exit", 64'(done), 64'd1);
    cmp("to_sticky", 64'(flush_timeout), 64'd1);
    // ext flush together with an accepted jump
    drive(1'b1, 1'b0, '0, '0, 1'b1, 32'h1234, 1'b1);
    prev_fr = flush_req;
    eps = 0;
    rvs = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_core);
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
      if (flush_req && !prev_fr) eps++;
      if (redirect_valid) rvs++;
      prev_fr = flush_req;
    end
    cmp("ej_episodes", 64'(eps), 64'd1);
    cmp("ej_redirects", 64'(rvs), 64'd1);
    cmp("ej_instret", instret, 64'd5);
    cmp("ej_target", 64'(redirect_target), 64'h1234);
    // instret wrap
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    m_base = 64'hFFFF_FFFF_FFFF_FFFF - m_ret;
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    #2 release dut.instret_q;
    @(negedge clk_core);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    cmp("wrap_instret", instret, 64'd0);
    // async reset in the middle of a writeback
    drive(1'b1, 1'b1, 5'd3, 32'h33, 1'b0, '0, 1'b0);
    @(posedge clk_core);
    #1 cmp("ar_rf_we_pre", 64'(rf_we), 64'd1);
    #1 rst_core_n = 1'b0;
    m_base = '0;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    #1;
    cmp("ar_rf_we", 64'(rf_we), 64'd0);
    cmp("ar_flush_req", 64'(flush_req), 64'd1);
    cmp("ar_instret", instret, 64'd0);
    cmp("ar_timeout", 64'(flush_timeout), 64'd0);
    cmp("ar_waddr", 64'(rf_waddr), 64'd0);
    @(negedge clk_core);
    rst_core_n = 1'b1;
    // random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk_core);
      drive(1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom_range(0, 7) == 0,
            $urandom, $urandom_range(0, 15) == 0);
      hold_mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
    end
    @(negedge clk_core);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    hold_mask = '0;
    repeat (5) @(negedge clk_core);
    #2 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
